// File: rtl/mt_reg_file_clr.sv
// Multithreaded integer register file with a post-reset zeroing sweep,
// a per-thread clear sequencer, and optional same-cycle write-to-read bypass.
module mt_reg_file_clr #(
  parameter int unsigned NUM_THREADS = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned BYPASS      = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           write_enable,
  input  logic [$clog2(NUM_THREADS)-1:0] tid_write,
  input  logic [4:0]                     a3,
  input  logic [DATA_WIDTH-1:0]          wd3,
  input  logic [$clog2(NUM_THREADS)-1:0] tid_read,
  input  logic [4:0]                     a1,
  input  logic [4:0]                     a2,
  output logic [DATA_WIDTH-1:0]          rd1,
  output logic [DATA_WIDTH-1:0]          rd2,
  input  logic                           clr_req,
  input  logic [$clog2(NUM_THREADS)-1:0] clr_tid,
  output logic                           ready,
  output logic                           clr_busy,
  output logic                           clr_done,
  output logic                           wr_drop
);

  localparam int unsigned TB  = $clog2(NUM_THREADS);
  localparam int unsigned RB  = $clog2(NUM_REGS);
  localparam int unsigned NE  = NUM_THREADS * NUM_REGS;
  localparam int unsigned AB  = TB + RB;
  localparam bit          BYP = (BYPASS != 0);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [AB-1:0]         r_ptr, w_ptr_nxt;
  logic [TB-1:0]         r_ctid, w_ctid_nxt;
  logic                  r_ready, r_clr_busy, r_clr_done, r_wr_drop;
  logic                  w_clr_done_nxt, w_wr_drop_nxt;
  logic [DATA_WIDTH-1:0] r_mem [NE];

  logic [RB-1:0]         w_a1, w_a2, w_a3;
  logic                  w_wr_nz;
  logic                  w_wr_do, w_sweep_we, w_mem_we;
  logic [AB-1:0]         w_sweep_addr, w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_rd_blank, w_byp_tid;

  // Only the low RB index bits address a register; the rest are don't-care.
  assign w_a1    = a1[RB-1:0];
  assign w_a2    = a2[RB-1:0];
  assign w_a3    = a3[RB-1:0];
  assign w_wr_nz = (w_a3 != '0);

  if (RB < 5) begin : g_idx_unused
    logic w_unused_hi;
    assign w_unused_hi = ^{a1[4:RB], a2[4:RB], a3[4:RB]};
  end

  // Next-state, write-port arbitration between writeback and the sweep.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_ctid_nxt     = r_ctid;
    w_wr_do        = 1'b0;
    w_sweep_we     = 1'b0;
    w_sweep_addr   = r_ptr;
    w_wr_drop_nxt  = 1'b0;
    w_clr_done_nxt = 1'b0;
    case (r_state)
      S_INIT: begin
        w_sweep_we    = 1'b1;
        w_ptr_nxt     = r_ptr + AB'(1);
        w_wr_drop_nxt = write_enable && w_wr_nz;
        if (r_ptr == AB'(NE - 1)) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        w_wr_do = write_enable && w_wr_nz;
        if (clr_req) begin
          w_ctid_nxt  = clr_tid;
          w_ptr_nxt   = AB'(1);
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_sweep_addr = {r_ctid, r_ptr[RB-1:0]};
        // A write to another thread takes the port and the sweep holds.
        if (write_enable && (tid_write != r_ctid)) begin
          w_wr_do = w_wr_nz;
        end else begin
          w_sweep_we    = 1'b1;
          w_ptr_nxt     = r_ptr + AB'(1);
          w_wr_drop_nxt = write_enable && w_wr_nz;
          if (r_ptr[RB-1:0] == RB'(NUM_REGS - 1)) begin
            w_state_nxt    = S_IDLE;
            w_clr_done_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
    if (rst) begin
      w_wr_do    = 1'b0;
      w_sweep_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_ptr      <= '0;
      r_ctid     <= '0;
      r_ready    <= 1'b0;
      r_clr_busy <= 1'b1;
      r_clr_done <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_ctid     <= w_ctid_nxt;
      r_ready    <= (w_state_nxt != S_INIT);
      r_clr_busy <= (w_state_nxt != S_IDLE);
      r_clr_done <= w_clr_done_nxt;
      r_wr_drop  <= w_wr_drop_nxt;
    end
  end

  assign w_mem_we    = w_wr_do || w_sweep_we;
  assign w_mem_addr  = w_wr_do ? {tid_write, w_a3} : w_sweep_addr;
  assign w_mem_wdata = w_wr_do ? wd3 : '0;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  // Zero rules (init, thread under clear, index 0) take precedence over bypass.
  assign w_rd_blank = (r_state == S_INIT) || ((r_state == S_CLEAR) && (tid_read == r_ctid));
  assign w_byp_tid  = BYP && w_wr_do && (tid_write == tid_read);

  assign rd1 = (w_rd_blank || (w_a1 == '0)) ? '0 :
               (w_byp_tid && (w_a3 == w_a1)) ? wd3 : r_mem[{tid_read, w_a1}];
  assign rd2 = (w_rd_blank || (w_a2 == '0)) ? '0 :
               (w_byp_tid && (w_a3 == w_a2)) ? wd3 : r_mem[{tid_read, w_a2}];

  assign ready    = r_ready;
  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;
  assign wr_drop  = r_wr_drop;

endmodule

// File: doc/mt_reg_file_clr.md
# mt_reg_file_clr

Parametrised multithreaded integer register file for the barrel core, the successor to the fixed 16-register-per-thread file. It adds a configurable register count per thread (RV32E or RV32I), same-cycle write-to-read bypass, a hardware zeroing sweep after reset, and a per-thread clear sequencer. The core uses the clear sequencer when it (re)launches a hart. It sits between decode (read ports) and writeback (write port).

## Interface

Parameters:
- NUM_THREADS, 8, hardware threads; power of two, ≥2.
- DATA_WIDTH, 32, register width.
- NUM_REGS, 16, registers per thread; 16 or 32 only.
- BYPASS, 1, 1 = forward the same-cycle write to the read ports; 0 = read the array only.

Ports (derived widths: TB = $clog2(NUM_THREADS), RB = $clog2(NUM_REGS)):
- clk  in  1  Sole clock. All state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- write_enable  in  1  Write request from writeback.
- tid_write  in  TB  Thread of the write.
- a3  in  5  Destination index. Only the low RB bits are used.
- wd3  in  DATA_WIDTH  Write data.
- tid_read  in  TB  Thread of both reads.
- a1, a2  in  5 each  Source indices. Only the low RB bits are used.
- rd1, rd2  out  DATA_WIDTH each  Combinational read data.
- clr_req  in  1  Request to zero one thread's registers.
- clr_tid  in  TB  Thread to clear. Sampled with clr_req.
- ready  out  1  High once the init sweep has completed.
- clr_busy  out  1  High while the INIT or CLEAR state is active.
- clr_done  out  1  One-cycle pulse when a thread clear completes.
- wr_drop  out  1  One-cycle pulse, registered, asserted the cycle after a write was discarded.

## Operation

- Storage is NUM_THREADS*NUM_REGS entries. Entry address is tid*NUM_REGS + idx.
- Index 0 of every thread reads as 0. Writes to index 0 are ignored silently; this is not a drop.
- The array has one write port. It is shared by writeback and the sweep pointer `ptr`.
- The FSM has three states: INIT, IDLE, CLEAR.
- INIT:
  - Entered from any state on rst.
  - `ptr` walks entries 0 .. NUM_THREADS*NUM_REGS-1, writing 0, one entry per cycle.
  - Every write_enable in this state is discarded and flagged by wr_drop.
  - Reads return 0.
  - clr_req is ignored.
  - After the last entry, go to IDLE.
- IDLE:
  - Normal writes are performed.
  - clr_req=1 latches clr_tid into `ctid`, sets `ptr`=1, and goes to CLEAR.
- CLEAR:
  - Zeroes ctid's registers 1..NUM_REGS-1.
  - Priority: a write_enable targeting another thread wins the port. The sweep holds `ptr` that cycle. The normal write is performed.
  - A write_enable targeting ctid is discarded and flagged by wr_drop. The sweep advances that cycle.
  - Reads with tid_read==ctid return 0 for all indices.
  - clr_req is ignored.
  - After register NUM_REGS-1 is written: clr_done pulses and the FSM goes to IDLE.
- Bypass (BYPASS=1): if write_enable, tid_write==tid_read, the write index equals the read index, the index is nonzero, and the write will be performed (not dropped), the read port returns wd3. Bypass never overrides the zero rules.
- Index truncation: with NUM_REGS=16, a3=5'd17 writes register 1.

## Timing

- Reset values: ready=0, clr_busy=1, clr_done=0, wr_drop=0, state=INIT, ptr=0.
- A cycle with rst high is a reset cycle. The first sweep write occurs in the first cycle with rst low.
- The init sweep takes exactly NUM_THREADS*NUM_REGS cycles. ready=1 and clr_busy=0 from the next cycle. Default parameters: 128 cycles.
- Writes have a latency of 1 cycle (visible on a non-bypassed read the next cycle). Reads are combinational, 0 cycles.
- Clear, stall-free: clr_req sampled in cycle T gives clr_busy=1 from T+1. Sweep writes occur in T+1..T+NUM_REGS-1. clr_done=1 and clr_busy=0 in T+NUM_REGS. Each stall cycle adds one cycle.
- clr_req held high: on return to IDLE, a new clear starts, because requests are level-sampled in IDLE.
- rst mid-CLEAR: the clear is aborted, no clr_done is produced, and a full INIT is performed.

## Test plan

- Reset sweep: assert rst 2 cycles, then hold write_enable=0. Required: ready rises exactly 128 cycles after rst falls, and every rd1/rd2 across all tid/idx reads 0.
- Write/read/bypass: write 32'hDEADBEEF to t3 r5. Same cycle, read t3 a1=5 → rd1=DEADBEEF with BYPASS=1; next cycle, BYPASS=0 → rd1=DEADBEEF. Write to r0 → reads 0, wr_drop stays 0.
- Thread clear: fill t2 r1..r15 with distinct values, pulse clr_req with clr_tid=2. Required: clr_done 16 cycles later, t2 all read 0, t1 values unchanged.
- Clear contention: during a t2 clear, write t4 r7=32'h1234 in 3 consecutive cycles. Required: clr_done delayed by 3 cycles, t4 r7=1234. A write to t2 r9 in the same clear → wr_drop=1 next cycle, and t2 r9 reads 0 afterwards.
- Reset mid-clear: assert rst at sweep step 6. Required: no clr_done, ready=0 for 128 cycles, and all entries read 0.
- NUM_REGS=32, NUM_THREADS=4: write t1 a3=31 then read t1 a1=31 → value. Init takes 128 cycles, and a clear takes 32 cycles (request to clr_done).
